fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
// - Sequences the shared 32x8 coefficient/sample ROM for the 16-tap FIR.
//   Computes one output y[n] = sum_k c[k] * x[(n-k) mod 16] per start request.
// - ROM map: coefficients at addresses 0..15, circular sample buffer at 16..31.
//   Both are 8-bit sign-magnitude Q1.7: bit7 is the sign, bits6:0 are the magnitude.
// - Sits between the top-level FIR control and the ROM. It owns rom_cs and rom_addr exclusively.
// PARAMETERS
// - TAPS    16   number of taps; fixed by the ROM map, do not override
// - X_BASE  16   ROM address of sample x[0]
// - ACC_W   20   two's-complement accumulator and y width; must be >= 19
// PORTS
// - clk       in   1      rising-edge clock
// - rst       in   1      asynchronous active-high reset
// - start     in   1      request one output; sampled only in IDLE
// - n_sel     in   4      output index n; latched when start is accepted
// - busy      out  1      high from the cycle after start is accepted until done
// - done      out  1      one-cycle pulse, coincident with y_valid
// - rom_cs    out  1      ROM chip select; high only during FETCH
// - rom_addr  out  5      ROM address
// - rom_data  in   8      ROM output; registered, valid 1 cycle after rom_addr
// - y         out  ACC_W  two's-complement result; holds until the next result
// - y_valid   out  1      one-cycle pulse when y updates
// BEHAVIOUR
// - Reset values: all outputs 0; FSM goes to IDLE; acc, c_reg, k and phase are cleared.
// - rst asserted mid-operation aborts immediately. No partial y is produced, and the block restarts only on a new start.
// - FSM states: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
// - IDLE: rom_cs=0, rom_addr=0. On start=1: latch n_sel, set k=0, phase=0, acc=0, go to FETCH.
// - FETCH (32 cycles): rom_cs=1. Two addresses are issued per tap.
//   - phase 0: rom_addr = k
//   - phase 1: rom_addr = X_BASE + ((n - k) & 4'hF); index wraps modulo 16
//   - phase toggles every cycle; k increments after phase 1.
//   - After k=15 phase 1, go to DRAIN.
// - Data capture, 1-cycle lag:
//   - cycle after a phase-0 issue: c_reg <= rom_data
//   - cycle after a phase-1 issue: acc <= acc + prod
// - prod: magnitude = c[6:0]*x[6:0] (14 bits); sign = c[7]^x[7].
//   Negate to two's complement when the sign is set; sign-extend to ACC_W.
//   -0 (0x80) contributes 0.
// - DRAIN (1 cycle): rom_cs=0. The last product is accumulated.
// - DONE (1 cycle): y <= acc; y_valid=1, done=1, busy=0; return to IDLE.
// - Latency: start sampled at edge E0 -> y_valid high in the cycle after edge E0+34. Throughput is one result per 35 cycles.
// - busy=1 in FETCH and DRAIN.
// - start while not in IDLE is ignored; it is not queued.
// - start in the same cycle DONE returns to IDLE is not seen; it must be presented in IDLE.
// - Range: |acc| <= 16*127*127 = 258064 < 2^19, so no overflow is possible at ACC_W >= 19.
// CONFIGURATION
// - FIR_SEQ_SAT_EN defined: adds port y_q (out, 8 bits), sign-magnitude Q1.7 result, registered with y.
//   - sign = acc<0
//   - mag = min(|acc| >> 7, 127)
//   - an all-zero magnitude gives 0x00, never 0x80
// - FIR_SEQ_SAT_EN undefined: y_q port and its logic are absent. All other behaviour is identical.
// TESTING (bench uses a behavioural ROM model with 1-cycle registered read)
// - Addresses:
//   - n_sel=3, start pulse -> rom_addr sequence 0,19,1,18,2,17,3,16,4,31,...,15,20.
//   - rom_cs high for exactly 32 cycles.
//   - y_valid 34 cycles after the start edge.
// - Magnitude: all coefficients 0x40, all samples 0x40 -> y=65536; y_q=0x7F (saturated).
// - Sign: all coefficients 0xC0, all samples 0x40 -> y=-65536 (0xF0000 at ACC_W=20); y_q=0xFF.
// - Wrap:
//   - c[0]=0x7F, others 0; sample@21=0x02; n_sel=5 -> y=254.
//   - c[1]=0x01, others 0; sample@31=0x85; n_sel=0 -> y=-5.
// - Start during busy: pulse start at FETCH cycle 10 with n_sel changed -> ignored.
//   Exactly one y_valid occurs, the result uses the original n.
// - Reset mid-op: assert rst in FETCH cycle 12 -> all outputs 0 the same cycle, no y_valid.
//   A following start then produces a correct full result.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// Sequencer for the shared 32x8 coefficient/sample ROM of a 16-tap sign-magnitude FIR.
// Optional saturated Q1.7 output y_q is enabled by defining FIR_SEQ_SAT_EN.
module fir_tap_sequencer #(
  parameter int TAPS   = 16,
  parameter int X_BASE = 16,
  parameter int ACC_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       n_sel,
  output logic             busy,
  output logic             done,
  output logic             rom_cs,
  output logic [4:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic [ACC_W-1:0] y,
`ifdef FIR_SEQ_SAT_EN
  output logic [7:0]       y_q,
`endif
  output logic             y_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state;
  logic [3:0]              n_reg;
  logic [3:0]              k;
  logic                    phase;
  logic                    cap_c;
  logic                    cap_x;
  logic [7:0]              c_reg;
  logic signed [ACC_W-1:0] acc;
  logic [13:0]             mag;
  logic signed [ACC_W-1:0] mag_ext;
  logic signed [ACC_W-1:0] prod;

  // rom_data always belongs to the address issued one cycle earlier
  always_comb begin
    mag     = {7'd0, c_reg[6:0]} * {7'd0, rom_data[6:0]};
    mag_ext = {{(ACC_W-14){1'b0}}, mag};
    prod    = (c_reg[7] ^ rom_data[7]) ? -mag_ext : mag_ext;
  end

`ifdef FIR_SEQ_SAT_EN
  logic [ACC_W-1:0] abs_acc;
  logic [ACC_W-1:0] abs_shr;
  logic [6:0]       q_mag;
  logic [7:0]       q_next;

  always_comb begin
    abs_acc = acc[ACC_W-1] ? 0 - acc : acc;
    abs_shr = abs_acc >> 7;
    q_mag   = (|abs_shr[ACC_W-1:7]) ? 7'h7F : abs_shr[6:0];
    q_next  = (q_mag == 7'd0) ? 8'h00 : {acc[ACC_W-1], q_mag};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      n_reg    <= '0;
      k        <= '0;
      phase    <= 1'b0;
      cap_c    <= 1'b0;
      cap_x    <= 1'b0;
      c_reg    <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
`ifdef FIR_SEQ_SAT_EN
      y_q      <= '0;
`endif
    end else begin
      done    <= 1'b0;
      y_valid <= 1'b0;
      cap_c   <= (state == FETCH) && !phase;
      cap_x   <= (state == FETCH) && phase;
      if (cap_c) c_reg <= rom_data;
      if (cap_x) acc <= acc + prod;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            n_reg    <= n_sel;
            k        <= '0;
            phase    <= 1'b0;
            acc      <= '0;
            busy     <= 1'b1;
            rom_cs   <= 1'b1;
            rom_addr <= '0;
          end
        end
        FETCH: begin
          if (!phase) begin
            phase    <= 1'b1;
            rom_addr <= 5'(X_BASE) + {1'b0, 4'(n_reg - k)};
          end else if (k == 4'(TAPS - 1)) begin
            state    <= DRAIN;
            phase    <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
          end else begin
            k        <= k + 4'd1;
            phase    <= 1'b0;
            rom_addr <= {1'b0, k + 4'd1};
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
        end
        DONE: begin
          state   <= IDLE;
          y       <= acc;
          y_valid <= 1'b1;
          done    <= 1'b1;
`ifdef FIR_SEQ_SAT_EN
          y_q     <= q_next;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a registered-read behavioural ROM.
// Covers y_q checks when FIR_SEQ_SAT_EN is defined.
module tb_fir_tap_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  n_sel;
  logic        busy;
  logic        done;
  logic        rom_cs;
  logic [4:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [19:0] y;
  logic        y_valid;
`ifdef FIR_SEQ_SAT_EN
  logic [7:0]  y_q;
`endif

  logic [7:0] mem [32];
  int total;
  int bad;

  fir_tap_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_sel    (n_sel),
    .busy     (busy),
    .done     (done),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .y        (y),
`ifdef FIR_SEQ_SAT_EN
    .y_q      (y_q),
`endif
    .y_valid  (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_cs) rom_data <= mem[rom_addr];
  end

  typedef struct {
    logic [7:0] c_fill;
    logic [7:0] x_fill;
    int         c_idx;
    logic [7:0] c_val;
    int         x_idx;
    logic [7:0] x_val;
    logic [3:0] n;
    bit         chk_addr;
    int         exp_y;
    logic [7:0] exp_yq;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      mem[i]      = v.c_fill;
      mem[16 + i] = v.x_fill;
    end
    if (v.c_idx >= 0) mem[v.c_idx] = v.c_val;
    if (v.x_idx >= 0) mem[v.x_idx] = v.x_val;
  endtask

  task automatic run_op(input string nm, input logic [3:0] n, input bit chk_addr,
                        input int inj_t, input logic [3:0] n2,
                        input int exp_y, input logic [7:0] exp_yq);
    int cs_cnt = 0, yv_cnt = 0, yv_t = -1, addr_bad = 0, busy_bad = 0, done_bad = 0;
    int y_cap = 0;
    logic [7:0] yq_cap = 8'h00;
    logic [3:0] kk;
    logic [4:0] ea;
    @(negedge clk);
    start = 1'b1;
    n_sel = n;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      if (rom_cs) cs_cnt++;
      if (chk_addr && t < 32) begin
        kk = 4'(t / 2);
        ea = (t % 2 == 0) ? {1'b0, kk} : 5'd16 + {1'b0, 4'(n - kk)};
        if (rom_addr !== ea || rom_cs !== 1'b1) addr_bad++;
      end
      if (busy !== (t <= 32)) busy_bad++;
      if (done !== y_valid) done_bad++;
      if (y_valid === 1'b1) begin
        yv_cnt++;
        yv_t  = t;
        y_cap = int'($signed(y));
`ifdef FIR_SEQ_SAT_EN
        yq_cap = y_q;
`endif
      end
      if (t == inj_t) begin
        start = 1'b1;
        n_sel = n2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({nm, " cs_cycles"}, cs_cnt, 32);
    check({nm, " yv_count"}, yv_cnt, 1);
    check({nm, " yv_latency"}, yv_t, 34);
    check({nm, " y"}, y_cap, exp_y);
    check({nm, " y_hold"}, int'($signed(y)), exp_y);
    check({nm, " busy_bad"}, busy_bad, 0);
    check({nm, " done_bad"}, done_bad, 0);
    if (chk_addr) check({nm, " addr_bad"}, addr_bad, 0);
`ifdef FIR_SEQ_SAT_EN
    check({nm, " y_q"}, int'(yq_cap), int'(exp_yq));
`endif
    $display("op %s n=%0d y=%0d exp=%0d yq=%02h exp_yq=%02h lat=%0d",
             nm, n, y_cap, exp_y, yq_cap, exp_yq, yv_t);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    n_sel = 4'd0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    //          c_fill x_fill c_idx c_val x_idx x_val  n    addr   exp_y    exp_yq
    vecs[0] = '{8'h40, 8'h40, -1,   8'h00, -1,  8'h00, 4'd3, 1'b1,  65536,  8'h7F};
    vecs[1] = '{8'hC0, 8'h40, -1,   8'h00, -1,  8'h00, 4'd0, 1'b0, -65536,  8'hFF};
    vecs[2] = '{8'h00, 8'h00,  0,   8'h7F, 21,  8'h02, 4'd5, 1'b1,  254,    8'h01};
    vecs[3] = '{8'h00, 8'h00,  1,   8'h01, 31,  8'h85, 4'd0, 1'b0, -5,      8'h00};
    vecs[4] = '{8'h01, 8'h7F, -1,   8'h00, -1,  8'h00, 4'd9, 1'b0,  2032,   8'h0F};
    vecs[5] = '{8'h80, 8'h7F, -1,   8'h00, -1,  8'h00, 4'd2, 1'b0,  0,      8'h00};
    vecs[6] = '{8'h00, 8'h00,  2,   8'h90, 21,  8'h08, 4'd7, 1'b0, -128,    8'h81};
    vecs[7] = '{8'h7F, 8'h7F, -1,   8'h00, -1,  8'h00, 4'd4, 1'b0,  258064, 8'h7F};
    vecs[8] = '{8'hFF, 8'h7F, -1,   8'h00, -1,  8'h00, 4'd11,1'b0, -258064, 8'hFF};

    #1;
    check("reset busy", int'(busy), 0);
    check("reset rom_cs", int'(rom_cs), 0);
    check("reset y", int'(y), 0);
    check("reset y_valid", int'(y_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      load(vecs[i]);
      run_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].chk_addr, -1, 4'd0,
             vecs[i].exp_y, vecs[i].exp_yq);
    end

    // start during FETCH with a different n must be ignored
    load(vecs[2]);
    run_op("start_busy", 4'd5, 1'b0, 10, 4'd9, 254, 8'h01);

    // reset in FETCH cycle 12 aborts with no result
    begin
      int yv_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      n_sel = 4'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst busy", int'(busy), 0);
      check("midrst rom_cs", int'(rom_cs), 0);
      check("midrst rom_addr", int'(rom_addr), 0);
      check("midrst y", int'(y), 0);
      check("midrst done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 40; t++) begin
        if (y_valid === 1'b1 || rom_cs === 1'b1) yv_cnt++;
        @(negedge clk);
      end
      check("midrst no_activity", yv_cnt, 0);
      $display("op midrst activity=%0d", yv_cnt);
    end
    run_op("after_rst", 4'd5, 1'b1, -1, 4'd0, 254, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
